intr_ctrl: RTL

//  Interrupt controller that drives the flush side of the IF/ID interface.
//  - Latches edge-triggered interrupt requests and picks a source by fixed priority.
//  - Waits until the pipeline can be safely redirected, then pulses Cancel_o to

---
 rtl/intr_ctrl_pkg.sv | 22 ++
 rtl/intr_pending.sv | 50 +++++
 rtl/intr_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// PC select codes and the default handler entry address.
package intr_ctrl_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CAUSE_W = 3;
    localparam int unsigned PCSEL_W = 2;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_TAKE = 2'b01,
        ST_ISR  = 2'b10,
        ST_RET  = 2'b11
    } state_e;

    localparam logic [PCSEL_W-1:0] PC_NORM = 2'b00;
    localparam logic [PCSEL_W-1:0] PC_HNDL = 2'b01;
    localparam logic [PCSEL_W-1:0] PC_EPC  = 2'b10;

    localparam logic [ADDR_W-1:0] DEF_HANDLER_ADDR = 32'h0000_0080;

endpackage

// File: rtl/intr_pending.sv
// Edge detection, pending latches and fixed-priority (lowest index) selection
// of interrupt sources.
module intr_pending
    import intr_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] int_req,
    input  logic [NUM_SRC-1:0] ack,
    output logic               any_pend,
    output logic [CAUSE_W-1:0] winner,
    output logic [NUM_SRC-1:0] winner_onehot
);

    logic [NUM_SRC-1:0] prev_q, prev_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;

    // A new rising edge outranks the acknowledge landing in the same cycle.
    always_comb begin
        prev_d = int_req;
        pend_d = (pend_q & ~ack) | (int_req & ~prev_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    // Scan from the top so the lowest pending index is the last one written.
    always_comb begin
        any_pend      = |pend_q;
        winner        = '0;
        winner_onehot = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                winner           = CAUSE_W'(i);
                winner_onehot    = '0;
                winner_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: takes pending interrupts when the pipeline can be
// redirected, flushes IF/ID + ID/EX, steers the PC to the handler or back to EPC.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int unsigned       NUM_SRC      = 4,
    parameter logic [ADDR_W-1:0] HANDLER_ADDR = DEF_HANDLER_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] IntReq_i,
    input  logic               Eret_i,
    input  logic               Safe_i,
    input  logic [ADDR_W-1:0]  EpcCand_i,
    output logic               Cancel_o,
    output logic [PCSEL_W-1:0] PCSel_o,
    output logic [ADDR_W-1:0]  Target_o,
    output logic [NUM_SRC-1:0] IntAck_o,
    output logic [ADDR_W-1:0]  Epc_o,
    output logic [CAUSE_W-1:0] Cause_o,
    output logic               IE_o
);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    epc_q, epc_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic [NUM_SRC-1:0]   ack_q, ack_d;
    logic                 cancel_q, cancel_d;
    logic [PCSEL_W-1:0]   pcsel_q, pcsel_d;
    logic [ADDR_W-1:0]    target_q, target_d;
    logic                 ie_q, ie_d;

    logic                 any_pend;
    logic [CAUSE_W-1:0]   winner;
    logic [NUM_SRC-1:0]   winner_onehot;

    intr_pending #(
        .NUM_SRC (NUM_SRC)
    ) u_pending (
        .clk           (clk),
        .rst           (rst),
        .int_req       (IntReq_i),
        .ack           (ack_q),
        .any_pend      (any_pend),
        .winner        (winner),
        .winner_onehot (winner_onehot)
    );

    // Next state plus registered Moore outputs decoded from the next state.
    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        ack_d    = '0;
        cancel_d = 1'b0;
        pcsel_d  = PC_NORM;
        target_d = '0;
        ie_d     = 1'b1;

        case (state_q)
            ST_RUN: begin
                if (any_pend && Safe_i) begin
                    state_d = ST_TAKE;
                    epc_d   = EpcCand_i;
                    cause_d = winner;
                    ack_d   = winner_onehot;
                end
            end
            ST_TAKE: state_d = ST_ISR;
            ST_ISR: begin
                if (Eret_i && Safe_i) begin
                    state_d = ST_RET;
                end
            end
            ST_RET:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase

        case (state_d)
            ST_TAKE: begin
                cancel_d = 1'b1;
                pcsel_d  = PC_HNDL;
                target_d = HANDLER_ADDR;
            end
            ST_ISR: begin
                ie_d = 1'b0;
            end
            ST_RET: begin
                cancel_d = 1'b1;
                pcsel_d  = PC_EPC;
                target_d = epc_d;
                ie_d     = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            epc_q    <= '0;
            cause_q  <= '0;
            ack_q    <= '0;
            cancel_q <= 1'b0;
            pcsel_q  <= PC_NORM;
            target_q <= '0;
            ie_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            ack_q    <= ack_d;
            cancel_q <= cancel_d;
            pcsel_q  <= pcsel_d;
            target_q <= target_d;
            ie_q     <= ie_d;
        end
    end

    assign Cancel_o = cancel_q;
    assign PCSel_o  = pcsel_q;
    assign Target_o = target_q;
    assign IntAck_o = ack_q;
    assign Epc_o    = epc_q;
    assign Cause_o  = cause_q;
    assign IE_o     = ie_q;

endmodule
